// File: rtl/hamming_scrub_ctrl_pkg.sv
// Shared definitions for the Hamming(7,4) scrub controller: default geometry,
// FSM state encoding and the saturating correction-counter helper.
package hamming_pkg;

    localparam int DEF_WIDTH       = 16;
    localparam int DEF_BLOCKS      = DEF_WIDTH / 4;
    localparam int DEF_PARITY_BITS = DEF_BLOCKS * 3;
    localparam int CORR_COUNT_W    = 8;

    typedef enum logic [2:0] {
        ST_RUN,
        ST_ENCODE,
        ST_CHECK,
        ST_CORRECT,
        ST_VERIFY,
        ST_FAULT
    } scrub_state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CORR_COUNT_W-1:0] sat_inc(input logic [CORR_COUNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/hamming_scrub_ctrl_if.sv
// Handshake and status bundle between the counter datapath/requester (master)
// and the scrub controller (slave).
interface hamming_scrub_ctrl_if import hamming_pkg::*; #(
    parameter int PARITY_BITS = DEF_PARITY_BITS
);
    logic                    count_req;
    logic                    count_ready;
    logic                    scrub_req;
    logic [PARITY_BITS-1:0]  syndrome;
    logic                    cnt_enable;
    logic                    corr_apply;
    logic                    scrub_busy;
    logic                    scrub_done;
    logic                    fault;
    logic [CORR_COUNT_W-1:0] corr_count;

    modport master (
        output count_req, scrub_req, syndrome,
        input  count_ready, cnt_enable, corr_apply, scrub_busy, scrub_done, fault, corr_count
    );

    modport slave (
        input  count_req, scrub_req, syndrome,
        output count_ready, cnt_enable, corr_apply, scrub_busy, scrub_done, fault, corr_count
    );
endinterface

// File: rtl/hamming_scrub_ctrl_scrub_timer.sv
// Scrub period timer: counts enabled cycles, clear has priority, tc flags the
// last count of the period.
module scrub_timer #(
    parameter int PERIOD = 256
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tc
);
    localparam int            TW   = $clog2(PERIOD + 1);
    localparam logic [TW-1:0] LAST = TW'(PERIOD - 1);

    logic [TW-1:0] count_q;

    // Period counter; clear wins over enable so leaving RUN always restarts it.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign tc = (count_q == LAST);

endmodule

// File: rtl/hamming_scrub_ctrl.sv
// Scrub controller for a Hamming(7,4)-protected counter: pauses the requester,
// has the datapath re-encode parity, checks the syndrome, applies up to
// MAX_RETRY corrections and raises a sticky fault if they do not clear it.
module hamming_scrub_ctrl import hamming_pkg::*; #(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int BLOCKS       = WIDTH / 4,
    parameter int PARITY_BITS  = BLOCKS * 3,
    parameter int SCRUB_PERIOD = 256,
    parameter int MAX_RETRY    = 2
) (
    input logic                 clk,
    input logic                 reset,
    hamming_scrub_ctrl_if.slave bus
);
    localparam int            RW          = $clog2(MAX_RETRY + 2);
    localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

    scrub_state_e            state_q, state_d;
    logic [RW-1:0]           retry_q;
    logic [CORR_COUNT_W-1:0] corr_count_q;
    logic                    count_ready_q, scrub_busy_q, scrub_done_q;
    logic                    corr_apply_q, fault_q;
    logic [PARITY_BITS-1:0]  syn;
    logic                    syn_nz;
    logic                    timer_tc;
    logic                    start_scrub;

    assign syn    = bus.syndrome;
    assign syn_nz = |syn;

    scrub_timer #(.PERIOD(SCRUB_PERIOD)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (start_scrub),
        .enable ((state_q == ST_RUN) && bus.count_req),
        .tc     (timer_tc)
    );

    // Next-state decode; scrub_req is only looked at in RUN, so requests
    // arriving mid-scrub are dropped rather than queued.
    always_comb begin
        // NOTE: defaults first so every path assigns state_d (no latch).
        state_d     = state_q;
        start_scrub = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (bus.scrub_req || (timer_tc && bus.count_req)) begin
                    start_scrub = 1'b1;
                    state_d     = ST_ENCODE;
                end
            end
            ST_ENCODE:  state_d = ST_CHECK;
            ST_CHECK:   state_d = syn_nz ? ST_CORRECT : ST_RUN;
            ST_CORRECT: state_d = ST_VERIFY;
            ST_VERIFY: begin
                if (!syn_nz) begin
                    state_d = ST_RUN;
                end else if (retry_q < RETRY_LIMIT) begin
                    state_d = ST_CORRECT;
                end else begin
                    state_d = ST_FAULT;
                end
            end
            ST_FAULT:   state_d = ST_FAULT;
            default:    state_d = ST_RUN;
        endcase
    end

    // State, retry/correction counters and registered outputs decoded from the
    // upcoming state so each output lines up with the state it describes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_RUN;
            retry_q       <= '0;
            corr_count_q  <= '0;
            count_ready_q <= 1'b1;
            scrub_busy_q  <= 1'b0;
            scrub_done_q  <= 1'b0;
            corr_apply_q  <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_ready_q <= (state_d == ST_RUN);
            scrub_busy_q  <= (state_d != ST_RUN) && (state_d != ST_FAULT);
            fault_q       <= (state_d == ST_FAULT);
            corr_apply_q  <= (state_d == ST_CORRECT);
            scrub_done_q  <= ((state_q == ST_CHECK) || (state_q == ST_VERIFY)) && (state_d == ST_RUN);
            if (state_d == ST_ENCODE) begin
                retry_q <= '0;
            end else if (state_d == ST_CORRECT) begin
                retry_q      <= retry_q + 1'b1;
                corr_count_q <= sat_inc(corr_count_q);
            end
        end
    end

    // cnt_enable follows count_req combinationally in RUN; gating with reset
    // keeps the datapath frozen while reset is held even though RUN is shown.
    assign bus.cnt_enable  = reset & count_ready_q & bus.count_req;
    assign bus.count_ready = count_ready_q;
    assign bus.scrub_busy  = scrub_busy_q;
    assign bus.scrub_done  = scrub_done_q;
    assign bus.corr_apply  = corr_apply_q;
    assign bus.fault       = fault_q;
    assign bus.corr_count  = corr_count_q;

endmodule

// File: tb/tb_hamming_scrub_ctrl.sv
// Bench for hamming_scrub_ctrl: a cycle-level protocol model predicts every
// output each cycle, directed scenarios add hand-computed literal checks.
module tb_hamming_scrub_ctrl;
    import hamming_pkg::*;

    localparam int P    = 8;
    localparam int MAXR = 2;
    localparam int PB   = 12;

    logic clk;
    logic reset;

    hamming_scrub_ctrl_if #(.PARITY_BITS(PB)) bus ();

    hamming_scrub_ctrl #(
        .SCRUB_PERIOD (P),
        .MAX_RETRY    (MAXR)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // model state: scrub phase k counts cycles since the scrub began
    // (1 = encode, 2 = check, odd >= 3 = correct, even >= 4 = verify)
    bit m_busy, m_fault, m_done;
    int m_k, m_acc, m_tries, m_corr;

    // syndrome policy: nonzero while the scrub phase is below bad_until
    int               bad_until = 0;
    logic [PB-1:0]    syn_pat   = '0;

    int n_corr_seen = 0;
    int n_done_seen = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_scrub();
        bus.scrub_req = 1'b1;
        tick();
        bus.scrub_req = 1'b0;
    endtask

    // Counts cycles with count_ready low, starting from 'start' already seen.
    task automatic count_low(input int start, output int stall);
        stall = start;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.count_ready) return;
            stall++;
        end
        n_cmp++;
        n_err++;
        $display("FAIL stall_timeout: count_ready still low after 50 cycles");
    endtask

    // Protocol model, advanced on each rising edge with that edge's inputs.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy = 0; m_fault = 0; m_done = 0;
            m_k = 0; m_acc = 0; m_tries = 0; m_corr = 0;
        end else begin
            m_done = 0;
            if (m_fault) begin
                m_fault = 1;
            end else if (!m_busy) begin
                if (bus.scrub_req || (bus.count_req && m_acc == P - 1)) begin
                    m_busy = 1; m_k = 1; m_acc = 0; m_tries = 0;
                end else if (bus.count_req) begin
                    m_acc++;
                end
            end else if (m_k == 1 || m_k % 2 == 1) begin
                m_k++;
            end else if (bus.syndrome == '0) begin
                m_busy = 0; m_done = 1;
            end else if (m_k == 2 || m_tries < MAXR) begin
                m_k++; m_tries++;
                m_corr = (m_corr < 255) ? m_corr + 1 : 255;
            end else begin
                m_busy = 0; m_fault = 1;
            end
        end
    end

    // Syndrome the datapath would present in the current scrub phase.
    always @(negedge clk) begin
        bus.syndrome = (m_busy && m_k < bad_until) ? syn_pat : '0;
    end

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        check("cyc_count_ready", 32'(bus.count_ready), 32'(!m_busy && !m_fault));
        check("cyc_cnt_enable",  32'(bus.cnt_enable),  32'(!m_busy && !m_fault && bus.count_req && reset));
        check("cyc_scrub_busy",  32'(bus.scrub_busy),  32'(m_busy));
        check("cyc_scrub_done",  32'(bus.scrub_done),  32'(m_done));
        check("cyc_fault",       32'(bus.fault),       32'(m_fault));
        check("cyc_corr_apply",  32'(bus.corr_apply),  32'(m_busy && m_k >= 3 && (m_k % 2 == 1)));
        check("cyc_corr_count",  32'(bus.corr_count),  32'(m_corr));
    end

    // Event tallies observed on the DUT for the scenario-level checks.
    always @(negedge clk) begin
        if (reset) begin
            if (bus.corr_apply) n_corr_seen++;
            if (bus.scrub_done) n_done_seen++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int accepts, stall, c0, d0;
        reset         = 1'b1;
        bus.count_req = 1'b1;
        bus.scrub_req = 1'b0;
        #1 reset = 1'b0;

        // reset state, with count_req already high
        repeat (3) tick();
        check("rst_count_ready", 32'(bus.count_ready), 32'd1);
        check("rst_cnt_enable",  32'(bus.cnt_enable),  32'd0);
        check("rst_corr_count",  32'(bus.corr_count),  32'd0);
        check("rst_fault",       32'(bus.fault),       32'd0);

        // continuous requests, clean periodic scrub
        c0 = n_corr_seen; d0 = n_done_seen;
        reset = 1'b1;
        accepts = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!bus.count_ready) break;
            if (bus.cnt_enable) accepts++;
        end
        check("period_accepts", 32'(accepts), 32'd8);
        count_low(1, stall);
        check("clean_stall", 32'(stall), 32'd2);
        tick();
        bus.count_req = 1'b0;
        repeat (3) tick();
        check("clean_done_count", 32'(n_done_seen - d0), 32'd1);
        check("clean_corr_count", 32'(bus.corr_count),   32'd0);
        check("clean_no_corr",    32'(n_corr_seen - c0), 32'd0);

        // forced scrub, one correction
        c0 = n_corr_seen; d0 = n_done_seen;
        bad_until = 3; syn_pat = 12'h003;
        pulse_scrub();
        count_low(0, stall);
        check("single_stall", 32'(stall), 32'd4);
        repeat (2) tick();
        check("single_corr_pulses", 32'(n_corr_seen - c0), 32'd1);
        check("single_corr_count",  32'(bus.corr_count),   32'd1);
        check("single_done",        32'(n_done_seen - d0), 32'd1);

        // scrub_req held three cycles: one scrub only
        d0 = n_done_seen;
        bad_until = 0;
        bus.scrub_req = 1'b1;
        repeat (3) tick();
        bus.scrub_req = 1'b0;
        repeat (5) tick();
        check("held_req_done", 32'(n_done_seen - d0), 32'd1);

        // timer expiry and scrub_req on the same edge
        d0 = n_done_seen;
        bus.count_req = 1'b1;
        repeat (7) tick();
        bus.scrub_req = 1'b1;
        tick();
        bus.scrub_req = 1'b0;
        bus.count_req = 1'b0;
        repeat (6) tick();
        check("coincident_done", 32'(n_done_seen - d0), 32'd1);

        // reset while a correction is being applied
        bad_until = 99; syn_pat = 12'h010;
        pulse_scrub();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.corr_apply) break;
        end
        check("pre_reset_corr_apply", 32'(bus.corr_apply), 32'd1);
        #1 reset = 1'b0;
        #1;
        check("mid_reset_corr_apply",  32'(bus.corr_apply),  32'd0);
        check("mid_reset_corr_count",  32'(bus.corr_count),  32'd0);
        check("mid_reset_count_ready", 32'(bus.count_ready), 32'd1);
        repeat (2) tick();
        c0 = n_corr_seen;
        reset = 1'b1;
        repeat (6) tick();
        check("post_reset_no_corr",   32'(n_corr_seen - c0), 32'd0);
        check("post_reset_corr_count", 32'(bus.corr_count),  32'd0);

        // stuck syndrome: two corrections then sticky fault
        c0 = n_corr_seen;
        pulse_scrub();
        repeat (10) tick();
        check("stuck_corr_pulses", 32'(n_corr_seen - c0), 32'd2);
        check("stuck_fault",       32'(bus.fault),        32'd1);
        check("stuck_count_ready", 32'(bus.count_ready),  32'd0);
        check("stuck_corr_count",  32'(bus.corr_count),   32'd2);
        bus.count_req = 1'b1;
        pulse_scrub();
        repeat (4) tick();
        check("fault_cnt_enable",  32'(bus.cnt_enable),   32'd0);
        check("fault_sticky",      32'(bus.fault),        32'd1);
        check("fault_no_corr",     32'(n_corr_seen - c0), 32'd2);
        bus.count_req = 1'b0;
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
        check("fault_cleared", 32'(bus.fault), 32'd0);

        // 300 corrections (two per scrub) saturate corr_count
        c0 = n_corr_seen; d0 = n_done_seen;
        bad_until = 5; syn_pat = 12'h003;
        for (int s = 0; s < 150; s++) begin
            pulse_scrub();
            repeat (7) tick();
        end
        check("sat_corr_pulses", 32'(n_corr_seen - c0), 32'd300);
        check("sat_done_count",  32'(n_done_seen - d0), 32'd150);
        check("sat_corr_count",  32'(bus.corr_count),   32'd255);
        check("sat_model_count", 32'(m_corr),           32'd255);
        check("sat_no_fault",    32'(bus.fault),        32'd0);

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
